// File: rtl/drive_sink_pkg.sv
// Shared types and constants for the drive-sink consumer that sits downstream of the
// two-way wait-merge controller.
package drive_sink_pkg;

    typedef enum logic [1:0] {
        StIdle,
        StValid,
        StFree,
        StGap
    } sink_state_e;

    localparam int unsigned SyncStagesDef = 2;
    localparam int unsigned CntWDef       = 4;
    localparam int unsigned FreeWDef      = 2;
    localparam int unsigned GapWDef       = 2;
    localparam int unsigned EvtWDef       = 16;

    // Width of the shared free/gap cycle counter.
    function automatic int unsigned tmr_width(input int unsigned free_w,
                                              input int unsigned gap_w);
        int unsigned m;
        m = (free_w > gap_w) ? free_w : gap_w;
        return $clog2(m + 1);
    endfunction

endpackage

// File: rtl/sync_edge_det.sv
// Multi-flop synchronizer for an asynchronous level, followed by a history flop that
// yields a single-cycle rising-edge strobe in the clk domain.
module sync_edge_det #(
    parameter int unsigned SYNC_STAGES = 2
) (
    input  logic clk_i,
    input  logic rst_i,
    input  logic d_i,
    output logic edge_o
);

    logic [SYNC_STAGES-1:0] sync_q;
    logic [SYNC_STAGES-1:0] fill_q;
    logic                   hist_q;
    logic                   hist_d;
    logic                   sync_out;

    assign sync_out = sync_q[SYNC_STAGES-1];

    // History is held high until the chain has refilled, so a level already high at
    // reset needs a low-then-high transition before it counts as an event.
    always_comb begin
        hist_d = 1'b1;
        if (fill_q[SYNC_STAGES-1]) begin
            hist_d = sync_out;
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            sync_q <= '0;
            fill_q <= '0;
            hist_q <= 1'b1;
        end else begin
            sync_q <= {sync_q[SYNC_STAGES-2:0], d_i};
            fill_q <= {fill_q[SYNC_STAGES-2:0], 1'b1};
            hist_q <= hist_d;
        end
    end

    assign edge_o = sync_out & ~hist_q;

endmodule

// File: rtl/drive_sink_sync.sv
// Queues synchronized drive events as tokens, hands them out over valid/ready and
// answers each consumed token with a fixed-width free pulse back to the merge.
module drive_sink_sync
    import drive_sink_pkg::*;
#(
    parameter int unsigned SYNC_STAGES = SyncStagesDef,
    parameter int unsigned CNT_W       = CntWDef,
    parameter int unsigned FREE_W      = FreeWDef,
    parameter int unsigned GAP_W       = GapWDef,
    parameter int unsigned EVT_W       = EvtWDef
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             i_drive,
    output logic             o_free,
    output logic             o_valid,
    input  logic             i_ready,
    output logic [CNT_W-1:0] o_pending,
    output logic             o_overflow,
    output logic [EVT_W-1:0] o_evt_cnt
);

    localparam int unsigned     TmrW   = tmr_width(FREE_W, GAP_W);
    localparam logic [CNT_W-1:0] CntMax = '1;

    sink_state_e      state_q, state_d;
    logic [TmrW-1:0]  tmr_q, tmr_d;
    logic [CNT_W-1:0] pending_q, pending_d;
    logic [EVT_W-1:0] evt_q, evt_d;
    logic             overflow_q, overflow_d;
    logic             valid_q, free_q;
    logic             drive_edge;
    logic             accept;

    sync_edge_det #(
        .SYNC_STAGES(SYNC_STAGES)
    ) u_sync_edge_det (
        .clk_i (clk),
        .rst_i (rst),
        .d_i   (i_drive),
        .edge_o(drive_edge)
    );

    assign accept = valid_q & i_ready;

    // A full counter drops only an unmatched edge; edge plus accept nets to zero.
    always_comb begin
        pending_d  = pending_q;
        overflow_d = overflow_q;
        if (drive_edge && !accept) begin
            if (pending_q == CntMax) begin
                overflow_d = 1'b1;
            end else begin
                pending_d = pending_q + 1'b1;
            end
        end else if (!drive_edge && accept) begin
            pending_d = pending_q - 1'b1;
        end
    end

    always_comb begin
        state_d = state_q;
        tmr_d   = tmr_q;
        evt_d   = evt_q;
        unique case (state_q)
            StIdle: begin
                if (pending_q != '0) begin
                    state_d = StValid;
                end
            end
            StValid: begin
                if (i_ready) begin
                    evt_d   = evt_q + 1'b1;
                    tmr_d   = '0;
                    state_d = StFree;
                end
            end
            StFree: begin
                if (tmr_q == TmrW'(FREE_W - 1)) begin
                    tmr_d   = '0;
                    state_d = StGap;
                end else begin
                    tmr_d = tmr_q + 1'b1;
                end
            end
            StGap: begin
                if (tmr_q == TmrW'(GAP_W - 1)) begin
                    tmr_d   = '0;
                    state_d = StIdle;
                end else begin
                    tmr_d = tmr_q + 1'b1;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= StIdle;
            tmr_q      <= '0;
            pending_q  <= '0;
            evt_q      <= '0;
            overflow_q <= 1'b0;
            valid_q    <= 1'b0;
            free_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            tmr_q      <= tmr_d;
            pending_q  <= pending_d;
            evt_q      <= evt_d;
            overflow_q <= overflow_d;
            valid_q    <= (state_d == StValid);
            free_q     <= (state_d == StFree);
        end
    end

    assign o_valid    = valid_q;
    assign o_free     = free_q;
    assign o_pending  = pending_q;
    assign o_overflow = overflow_q;
    assign o_evt_cnt  = evt_q;

endmodule
